// File: rtl/gost_adder_pkg.sv
// gost_adder_pkg: shared constants and helpers for the prefix adder/subtractor family
package gost_adder_pkg;
    localparam int PA_MIN_WIDTH = 8;
    localparam int PA_MAX_WIDTH = 64;
    localparam int BPC_WIDTH = 1;
    function automatic int ks_levels(input int width);
        return $clog2(width);
    endfunction
    function automatic int ks_split(input int width);
        return (ks_levels(width) + 1) / 2;
    endfunction
    function automatic bit width_ok(input int width);
        return width >= PA_MIN_WIDTH && width <= PA_MAX_WIDTH && (width & (width - 1)) == 0;
    endfunction
endpackage

// File: rtl/borrow_prop_cell.sv
// borrow_prop_cell: Kogge-Stone group operator (gL,pL)o(gR,pR) = (gL | pL&gR, pL&pR)
module borrow_prop_cell
    import gost_adder_pkg::*;
(
    input  logic [BPC_WIDTH-1:0] gl,
    input  logic [BPC_WIDTH-1:0] pl,
    input  logic [BPC_WIDTH-1:0] gr,
    input  logic [BPC_WIDTH-1:0] pr,
    output logic [BPC_WIDTH-1:0] g,
    output logic [BPC_WIDTH-1:0] p
);
    assign g = gl | (pl & gr);
    assign p = pl & pr;
endmodule

// File: rtl/prefix_subtractor_pipe.sv
// prefix_subtractor_pipe: 3-stage valid/ready A-B subtractor built on a split Kogge-Stone tree
module prefix_subtractor_pipe
    import gost_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ivalid,
    output logic             oready,
    input  logic [WIDTH-1:0] iminuend,
    input  logic [WIDTH-1:0] isubtrahend,
    output logic             ovalid,
    input  logic             iready,
    output logic [WIDTH-1:0] odiff,
    output logic             oborrow
);
    localparam int LVL = ks_levels(WIDTH);
    localparam int SPLIT = ks_split(WIDTH);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("prefix_subtractor_pipe: WIDTH must be a power of two in 8..64");
    end

    logic v1, v2, v3, en1, en2, en3;
    logic [WIDTH-1:0] g_in, p_in, g1, p1, g2, p2, h2;
    logic [LVL:0][WIDTH-1:0] gt, pt;
    logic [WIDTH-1:0] unused_p;

    assign en3 = ~v3 | iready;
    assign en2 = ~v2 | en3;
    assign en1 = ~v1 | en2;
    assign oready = en1;
    assign ovalid = v3;

    // carry-in of 1 folds into bit 0: g0 | p0
    assign p_in = iminuend ^ ~isubtrahend;
    assign g_in = (iminuend & ~isubtrahend) | {{(WIDTH-1){1'b0}}, p_in[0]};

    assign gt[0] = g1;
    assign pt[0] = p1;
    assign unused_p = pt[LVL];

    // levels below SPLIT feed S2; the rest restart from the S2 registers
    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int D = 1 << k;
        logic [WIDTH-1:0] gi, pi;
        assign gi = (k == SPLIT) ? g2 : gt[k];
        assign pi = (k == SPLIT) ? p2 : pt[k];
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_op
                borrow_prop_cell u_cell (
                    .gl(gi[i]),
                    .pl(pi[i]),
                    .gr(gi[i-D]),
                    .pr(pi[i-D]),
                    .g (gt[k+1][i]),
                    .p (pt[k+1][i])
                );
            end else begin : g_pass
                assign gt[k+1][i] = gi[i];
                assign pt[k+1][i] = pi[i];
            end
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            g1 <= '0;
            p1 <= '0;
            g2 <= '0;
            p2 <= '0;
            h2 <= '0;
            odiff <= '0;
            oborrow <= 1'b0;
        end else begin
            if (en1) begin
                v1 <= ivalid;
                g1 <= g_in;
                p1 <= p_in;
            end
            if (en2) begin
                v2 <= v1;
                g2 <= gt[SPLIT];
                p2 <= pt[SPLIT];
                h2 <= p1;
            end
            if (en3) begin
                v3 <= v2;
                odiff <= h2 ^ {gt[LVL][WIDTH-2:0], 1'b1};
                oborrow <= ~gt[LVL][WIDTH-1];
            end
        end
    end
endmodule
